// File: rtl/sram_pkg.sv
// Shared types and defaults for the packet SRAM page allocator.
package sram_pkg;
  localparam int unsigned PAGE_NUM_DEF = 2048;
  localparam int unsigned PAGE_AW_DEF  = $clog2(PAGE_NUM_DEF);
  localparam int unsigned LINK_W_DEF   = 16;

  typedef logic [PAGE_AW_DEF-1:0] page_t;
  typedef logic [LINK_W_DEF-1:0]  link_t;

  typedef enum logic {FILL, RUN} alloc_state_e;
endpackage

// File: rtl/sram_sdp_ram.sv
// Simple dual-port RAM, read-first, one-cycle registered read.
module sram_sdp_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2048,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sram_page_allocator.sv
// Free-page FIFO with self-fill after reset, plus per-page jump table.
module sram_page_allocator
  import sram_pkg::*;
#(
  parameter int unsigned PAGE_NUM = PAGE_NUM_DEF,
  parameter int unsigned LINK_W   = LINK_W_DEF,
  localparam int unsigned PAGE_AW = $clog2(PAGE_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               init_done,
  input  logic               alloc_req,
  output logic               alloc_vld,
  output logic [PAGE_AW-1:0] alloc_page,
  output logic               alloc_fail,
  input  logic               free_req,
  input  logic [PAGE_AW-1:0] free_page,
  output logic               free_ovf,
  output logic [PAGE_AW:0]   free_cnt,
  input  logic               link_wr_en,
  input  logic [PAGE_AW-1:0] link_wr_page,
  input  logic [LINK_W-1:0]  link_wr_next,
  input  logic [PAGE_AW-1:0] link_rd_page,
  output logic [LINK_W-1:0]  link_rd_next
);
  if (PAGE_NUM < 4 || (PAGE_NUM & (PAGE_NUM - 1)) != 0) begin : g_bad_page_num
    $error("sram_page_allocator: PAGE_NUM must be a power of two >= 4");
  end

  alloc_state_e state, state_nxt;
  logic [PAGE_AW-1:0] head, tail, fill;
  logic               in_fill, pool_empty, pool_full;
  logic               alloc_acc, alloc_rej, free_acc, free_rej;
  logic               ram_we;
  logic [PAGE_AW-1:0] ram_wa, ram_wd, ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == FILL && fill == PAGE_AW'(PAGE_NUM - 1)) state_nxt = RUN;
  end

  // A same-cycle free never rescues an alloc at empty: decisions use the registered count.
  always_comb begin
    in_fill    = (state == FILL);
    pool_empty = (free_cnt == '0);
    pool_full  = (free_cnt == (PAGE_AW + 1)'(PAGE_NUM));
    alloc_acc  = !in_fill && alloc_req && !pool_empty;
    alloc_rej  = alloc_req && !alloc_acc;
    free_acc   = !in_fill && free_req && !pool_full;
    free_rej   = !in_fill && free_req && pool_full;
    ram_we     = in_fill || free_acc;
    ram_wa     = in_fill ? fill : tail;
    ram_wd     = in_fill ? fill : free_page;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      free_cnt   <= '0;
      alloc_vld  <= 1'b0;
      alloc_fail <= 1'b0;
      free_ovf   <= 1'b0;
    end else begin
      alloc_vld  <= alloc_acc;
      alloc_fail <= alloc_rej;
      free_ovf   <= free_rej;
      if (alloc_acc) head <= head + 1'b1;
      if (ram_we)    tail <= tail + 1'b1;
      if (in_fill)   fill <= fill + 1'b1;
      if (in_fill) begin
        free_cnt <= free_cnt + 1'b1;
      end else begin
        case ({alloc_acc, free_acc})
          2'b10:   free_cnt <= free_cnt - 1'b1;
          2'b01:   free_cnt <= free_cnt + 1'b1;
          default: free_cnt <= free_cnt;
        endcase
      end
    end
  end

  assign init_done  = (state == RUN);
  assign alloc_page = alloc_vld ? ram_q : '0;

  sram_sdp_ram #(.WIDTH(PAGE_AW), .DEPTH(PAGE_NUM)) u_null_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_addr (head),
    .rd_data (ram_q)
  );

  sram_sdp_ram #(.WIDTH(LINK_W), .DEPTH(PAGE_NUM)) u_jump_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (link_wr_en),
    .wr_addr (link_wr_page),
    .wr_data (link_wr_next),
    .rd_addr (link_rd_page),
    .rd_data (link_rd_next)
  );
endmodule
